udp_tx_framer: RTL and testbench
================================

// Module: udp_tx_framer
// PURPOSE
//  Transmit-side counterpart of the RX UDP filter. Buffers one UDP payload frame from a byte-wide
//  AXI-Stream source, prepends Ethernet II / IPv4 / UDP headers, and streams the full frame
//  (42 header bytes + payload) to the MAC TX. The MAC adds preamble, padding and FCS.
//  Store-and-forward, one frame in flight. The length fields and the IPv4 checksum need the
//  payload length before the first header byte goes out.
// PARAMETERS
//  DST_MAC      48'h00_0A_35_00_00_02  destination MAC, bytes 0-5 (MSB first)
//  SRC_MAC      48'h00_0A_35_00_00_01  source MAC, bytes 6-11
//  SRC_IP       32'hC0A8010A           source IPv4 address, 192.168.1.10
//  DST_IP       32'hC0A80114           destination IPv4 address, 192.168.1.20
//  SRC_PORT     16'd1234               UDP source port
//  DST_PORT     16'd1234               UDP destination port
//  TTL          8'd64                  IPv4 time to live
//  MAX_PAYLOAD  256                    payload buffer depth in bytes; must be 1..1472
// PORTS
//  clk            in   1  system clock, 125 MHz
//  rst_n          in   1  asynchronous active-low reset
//  s_axis_tdata   in   8  payload byte
//  s_axis_tvalid  in   1  payload byte valid
//  s_axis_tlast   in   1  last payload byte of the frame
//  s_axis_tready  out  1  framer accepts a payload byte
//  m_axis_tdata   out  8  Ethernet frame byte, to MAC TX
//  m_axis_tvalid  out  1  frame byte valid
//  m_axis_tlast   out  1  last byte of the frame
//  m_axis_tready  in   1  MAC accepts a byte
// BEHAVIOUR
//  Reset: state=CAPTURE, buffer count=0, IP ID=0; s_axis_tready=0 during reset, then 1;
//   m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
//  Transfer rule: a byte transfers only when valid & ready in the same cycle, on both sides.
//  CAPTURE: s_axis_tready=1. Each accepted byte is written to buf[cnt], then cnt++.
//   - Accepted byte with tlast: latch L=cnt+1, then go to CSUM.
//   - Accepted byte without tlast while cnt==MAX_PAYLOAD-1: go to DROP (frame too large).
//  DROP: s_axis_tready=1 and bytes are discarded. On tlast: cnt=0, go to CAPTURE.
//   No output is produced and IP ID is not incremented.
//  CSUM: one cycle with s_axis_tready=0. Register the IPv4 checksum here:
//   - sum the 10 header words with the checksum word taken as 0;
//   - use a 20-bit accumulator, fold the carries twice, then one's-complement the result.
//   Then go to HDR.
//  HDR: emit header bytes 0..41, MSB first; m_axis_tvalid=1.
//   0-5 DST_MAC | 6-11 SRC_MAC | 12-13 08 00 | 14 45 | 15 00 | 16-17 IP total = 28+L
//   18-19 IP ID | 20-21 40 00 (DF) | 22 TTL | 23 11 | 24-25 checksum | 26-29 SRC_IP
//   30-33 DST_IP | 34-35 SRC_PORT | 36-37 DST_PORT | 38-39 UDP length = 8+L | 40-41 00 00.
//   UDP checksum is always 0 (disabled).
//  PAYLOAD: emit buf[0..L-1]; m_axis_tlast=1 only on buf[L-1].
//   After that byte is accepted: IP ID++ (wraps FFFF->0000), cnt=0, go to CAPTURE.
//  Outputs are registered. The first header byte is valid 2 cycles after the tlast payload byte
//   is accepted (1 CSUM cycle + register).
//  Backpressure: while m_axis_tvalid=1 & m_axis_tready=0, m_axis_tdata/tlast hold stable and the
//   byte index holds. m_axis_tvalid never drops mid-frame.
//  s_axis_tready=0 in CSUM, HDR and PAYLOAD: no overlap between capture and transmit.
//  Single-byte payload (L=1) is legal: 43-byte frame.
//  Reset mid-frame: the output frame is truncated with no tlast, and the partial input frame is
//   discarded. The downstream MAC must handle this.
// TESTING
//  T1 payload AA 55 FF (last on FF), m_axis_tready=1 -> 45 bytes out; [12:13]=08 00;
//     [16:17]=00 1F; [18:19]=00 00; [23]=11; [24:25]=B7 5F; [36:37]=04 D2; [38:39]=00 0B;
//     [42:44]=AA 55 FF; tlast only on byte 44.
//  T2 repeat T1 -> [18:19]=00 01 and [24:25]=B7 5E.
//  T3 T1 with m_axis_tready toggling 1,0,0,1 -> byte sequence identical to T1; outputs stable
//     during stalls; m_axis_tvalid never drops before tlast.
//  T4 300-byte payload (MAX_PAYLOAD=256) -> no output, s_axis_tready stays 1 for all 300 bytes;
//     a following T1 frame is correct with ID 00 00.
//  T5 assert rst_n=0 at header byte 20 -> next cycle m_axis_tvalid=0 and s_axis_tready=0;
//     after release, T1 is correct with ID 00 00.
//  T6 1-byte payload 7E -> 43 bytes; [16:17]=00 1D; [38:39]=00 09; byte 42=7E with tlast.

Source files
------------

// File: rtl/udp_tx_framer.sv
// Store-and-forward UDP/IPv4/Ethernet II transmit framer.
// Buffers one payload frame, then emits the 42-byte header followed by the payload.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_CAPTURE | accepting payload bytes into the buffer
// ST_DROP    | oversize frame, discarding bytes until tlast
// ST_CSUM    | one cycle to register the IPv4 header checksum
// ST_HDR     | streaming header bytes 0..41
// ST_PAYLOAD | streaming buffered payload bytes, tlast on the final one
module udp_tx_framer #(
    parameter logic [47:0] DST_MAC     = 48'h00_0A_35_00_00_02,
    parameter logic [47:0] SRC_MAC     = 48'h00_0A_35_00_00_01,
    parameter logic [31:0] SRC_IP      = 32'hC0A8010A,
    parameter logic [31:0] DST_IP      = 32'hC0A80114,
    parameter logic [15:0] SRC_PORT    = 16'd1234,
    parameter logic [15:0] DST_PORT    = 16'd1234,
    parameter logic [7:0]  TTL         = 8'd64,
    parameter int          MAX_PAYLOAD = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    input  logic       s_axis_tlast,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    input  logic       m_axis_tready
);

    localparam int CW      = $clog2(MAX_PAYLOAD + 1);
    localparam int AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int IW      = (CW > 6) ? CW : 6;
    localparam int HDR_LEN = 42;

    typedef enum logic [2:0] {
        ST_CAPTURE,
        ST_DROP,
        ST_CSUM,
        ST_HDR,
        ST_PAYLOAD
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   len_q, len_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [15:0]     id_q, id_d;
    logic [15:0]     csum_q, csum_d;
    logic            s_rdy_q, s_rdy_d;
    logic            m_valid_q, m_valid_d;
    logic            m_last_q, m_last_d;
    logic [7:0]      m_data_q, m_data_d;
    logic            wr_en;
    logic            s_acc;
    logic            m_free;

    logic [7:0]      buf_mem [MAX_PAYLOAD];
    logic [15:0]     ip_total;
    logic [15:0]     udp_len;
    logic [19:0]     csum_acc;
    logic [16:0]     csum_fold1;
    logic [15:0]     csum_fold2;
    logic [HDR_LEN*8-1:0] hdr_vec;
    logic [7:0]      hdr_byte;
    logic [7:0]      pay_byte;

    assign ip_total = 16'd28 + 16'(len_q);
    assign udp_len  = 16'd8 + 16'(len_q);

    // 20-bit sum of the ten header words (checksum field as zero), folded twice
    assign csum_acc = 20'h04500 + 20'(ip_total) + 20'(id_q) + 20'h04000
                    + {4'h0, TTL, 8'h11}
                    + {4'h0, SRC_IP[31:16]} + {4'h0, SRC_IP[15:0]}
                    + {4'h0, DST_IP[31:16]} + {4'h0, DST_IP[15:0]};
    assign csum_fold1 = {1'b0, csum_acc[15:0]} + {13'h0, csum_acc[19:16]};
    assign csum_fold2 = csum_fold1[15:0] + {15'h0, csum_fold1[16]};

    assign hdr_vec = {DST_MAC, SRC_MAC, 16'h0800, 8'h45, 8'h00, ip_total,
                      id_q, 16'h4000, TTL, 8'h11, csum_q, SRC_IP, DST_IP,
                      SRC_PORT, DST_PORT, udp_len, 16'h0000};
    assign hdr_byte = hdr_vec[(HDR_LEN - 1 - int'(idx_q[5:0])) * 8 +: 8];
    assign pay_byte = buf_mem[idx_q[AW-1:0]];

    assign s_acc  = s_rdy_q & s_axis_tvalid;
    assign m_free = ~m_valid_q | m_axis_tready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        idx_d     = idx_q;
        id_d      = id_q;
        csum_d    = csum_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        wr_en     = 1'b0;

        case (state_q)
            ST_CAPTURE: begin
                if (s_acc) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    if (s_axis_tlast) begin
                        len_d   = cnt_q + CW'(1);
                        state_d = ST_CSUM;
                    end else if (cnt_q == CW'(MAX_PAYLOAD - 1)) begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (s_acc && s_axis_tlast) begin
                    cnt_d   = '0;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CSUM: begin
                csum_d  = ~csum_fold2;
                idx_d   = '0;
                state_d = ST_HDR;
            end
            ST_HDR: begin
                if (m_free) begin
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    m_data_d  = hdr_byte;
                    if (idx_q == IW'(HDR_LEN - 1)) begin
                        idx_d   = '0;
                        state_d = ST_PAYLOAD;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            ST_PAYLOAD: begin
                // final byte is already in the output register: wait for its handshake
                if (m_valid_q && m_last_q) begin
                    if (m_axis_tready) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        id_d      = id_q + 16'd1;
                        cnt_d     = '0;
                        state_d   = ST_CAPTURE;
                    end
                end else if (m_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = pay_byte;
                    m_last_d  = (idx_q == IW'(len_q) - IW'(1));
                    idx_d     = idx_q + IW'(1);
                end
            end
            default: state_d = ST_CAPTURE;
        endcase

        s_rdy_d = (state_d == ST_CAPTURE) || (state_d == ST_DROP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CAPTURE;
            cnt_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            id_q      <= '0;
            csum_q    <= '0;
            s_rdy_q   <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            id_q      <= id_d;
            csum_q    <= csum_d;
            s_rdy_q   <= s_rdy_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) buf_mem[cnt_q[AW-1:0]] <= s_axis_tdata;
    end

    assign s_axis_tready = s_rdy_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tdata  = m_data_q;

endmodule

// File: tb/tb_udp_tx_framer.sv
// Self-checking bench for udp_tx_framer: fixed vectors, corner sequences and
// randomized frames compared against a byte-level frame model.
module tb_udp_tx_framer;

    localparam int MAXP = 256;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_tdata;
    logic       s_tvalid, s_tlast, s_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid, m_tlast, m_tready;

    always #4 clk = ~clk;

    udp_tx_framer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready)
    );

    typedef struct {
        int          len;
        logic [23:0] data;
        int          rdy_mode;
        logic [15:0] id;
        logic [15:0] total;
        logic [15:0] csum;
        logic [15:0] udp;
    } vec_t;

    vec_t       vecs[4];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         model_id = 0;
    logic [7:0] pl_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void push_bytes(input logic [47:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(8'((v >> (8 * i)) & 48'hFF));
    endfunction

    // Frame built from the protocol layout with plain integer arithmetic
    function automatic void build_frame();
        int unsigned w[10];
        int unsigned s;
        int          len;
        len = pl_q.size();
        w = '{32'h4500, 28 + len, model_id & 32'hFFFF, 32'h4000, (64 << 8) | 17, 0,
              32'hC0A8, 32'h010A, 32'hC0A8, 32'h0114};
        s = 0;
        foreach (w[k]) s += w[k];
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        s = ~s & 32'hFFFF;
        exp_q.delete();
        push_bytes(48'h000A35000002, 6);
        push_bytes(48'h000A35000001, 6);
        push_bytes(48'h0800, 2);
        push_bytes(48'h45, 1);
        push_bytes(48'h00, 1);
        push_bytes(48'(28 + len), 2);
        push_bytes(48'(model_id & 32'hFFFF), 2);
        push_bytes(48'h4000, 2);
        push_bytes(48'd64, 1);
        push_bytes(48'd17, 1);
        push_bytes(48'(s), 2);
        push_bytes(48'hC0A8010A, 4);
        push_bytes(48'hC0A80114, 4);
        push_bytes(48'd1234, 2);
        push_bytes(48'd1234, 2);
        push_bytes(48'(8 + len), 2);
        push_bytes(48'h0, 2);
        foreach (pl_q[k]) exp_q.push_back(pl_q[k]);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00; m_tready = 1'b0;
        #1;
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_m_tdata", m_tdata, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_s_tready", s_tready, 1);
        model_id = 0;
    endtask

    task automatic send_payload(input bit gaps);
        int i = 0;
        int cyc = 0;
        logic rdy;
        while (i < pl_q.size() && cyc < 5000) begin
            s_tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_tdata  = pl_q[i];
            s_tlast  = (i == pl_q.size() - 1);
            check("cap_s_tready", s_tready, 1);
            check("cap_m_tvalid_idle", m_tvalid, 0);
            rdy = s_tready;
            @(posedge clk);
            if (s_tvalid && rdy) i++;
            #1;
            cyc++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (i < pl_q.size()) check("send_timeout", i, pl_q.size());
    endtask

    task automatic collect(input int rdy_mode);
        int   cyc = 0;
        int   lat = -1;
        bit   done = 0, started = 0, hold = 0;
        logic v, l, r;
        logic [7:0] d, hd;
        logic hl;
        got_q.delete();
        hd = 8'h00; hl = 1'b0;
        while (!done && cyc < 4000) begin
            v = m_tvalid; d = m_tdata; l = m_tlast;
            if (hold) begin
                check("stall_valid", v, 1);
                check("stall_data", d, hd);
                check("stall_last", l, hl);
            end
            if (started && !v) check("valid_drop", v, 1);
            if (v && !started) begin
                started = 1;
                lat = cyc;
            end
            case (rdy_mode)
                1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       r = 1'($urandom_range(0, 1));
                default: r = 1'b1;
            endcase
            m_tready = r;
            @(posedge clk);
            if (v && r) begin
                got_q.push_back(d);
                if (l) done = 1;
            end
            hold = v && !r;
            hd = d; hl = l;
            #1;
            cyc++;
        end
        m_tready = 1'b0;
        check("collect_done", done, 1);
        check("first_byte_latency", lat, 2);
    endtask

    task automatic run_frame(input int rdy_mode, input bit gaps);
        send_payload(gaps);
        if (pl_q.size() <= MAXP) begin
            build_frame();
            collect(rdy_mode);
            check("frame_len", got_q.size(), exp_q.size());
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
                check($sformatf("byte%0d", i), got_q[i], exp_q[i]);
            model_id = (model_id + 1) & 16'hFFFF;
        end else begin
            repeat (10) begin
                check("drop_m_tvalid", m_tvalid, 0);
                check("drop_s_tready", s_tready, 1);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic load_vec(input vec_t vv);
        pl_q.delete();
        for (int k = 0; k < vv.len; k++) pl_q.push_back(vv.data[8 * (vv.len - 1 - k) +: 8]);
    endtask

    task automatic check_fields(input vec_t vv);
        if (got_q.size() >= 42 + vv.len) begin
            check("ethertype", {got_q[12], got_q[13]}, 16'h0800);
            check("ip_total", {got_q[16], got_q[17]}, vv.total);
            check("ip_id", {got_q[18], got_q[19]}, vv.id);
            check("ip_proto", got_q[23], 8'h11);
            check("ip_csum", {got_q[24], got_q[25]}, vv.csum);
            check("udp_dport", {got_q[36], got_q[37]}, 16'h04D2);
            check("udp_len", {got_q[38], got_q[39]}, vv.udp);
            for (int k = 0; k < vv.len; k++)
                check("payload", got_q[42 + k], vv.data[8 * (vv.len - 1 - k) +: 8]);
        end else begin
            check("short_frame", got_q.size(), 42 + vv.len);
        end
    endtask

    initial begin
        int acc;
        int cyc;
        int len;
        rst_n = 1'b0;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00; m_tready = 1'b0;

        vecs[0] = '{len: 3, data: 24'hAA55FF, rdy_mode: 0, id: 16'h0000, total: 16'h001F, csum: 16'hB75F, udp: 16'h000B};
        vecs[1] = '{len: 3, data: 24'hAA55FF, rdy_mode: 0, id: 16'h0001, total: 16'h001F, csum: 16'hB75E, udp: 16'h000B};
        vecs[2] = '{len: 3, data: 24'hAA55FF, rdy_mode: 1, id: 16'h0002, total: 16'h001F, csum: 16'hB75D, udp: 16'h000B};
        vecs[3] = '{len: 1, data: 24'h00007E, rdy_mode: 0, id: 16'h0003, total: 16'h001D, csum: 16'hB75E, udp: 16'h0009};

        do_reset();
        foreach (vecs[v]) begin
            load_vec(vecs[v]);
            run_frame(vecs[v].rdy_mode, 1'b0);
            check_fields(vecs[v]);
        end

        // oversize frame is swallowed; the next frame still carries ID 0
        do_reset();
        pl_q.delete();
        for (int k = 0; k < 300; k++) pl_q.push_back(8'($urandom));
        run_frame(0, 1'b1);
        load_vec(vecs[0]);
        run_frame(0, 1'b0);
        check_fields(vecs[0]);

        // reset while header byte 20 is on the output
        load_vec(vecs[0]);
        send_payload(1'b0);
        acc = 0;
        cyc = 0;
        while (!(m_tvalid && acc == 20) && cyc < 200) begin
            m_tready = 1'b1;
            @(posedge clk);
            if (m_tvalid) acc++;
            #1;
            cyc++;
        end
        check("reach_hdr20", acc, 20);
        rst_n = 1'b0;
        #1;
        check("midrst_m_tvalid", m_tvalid, 0);
        check("midrst_s_tready", s_tready, 0);
        @(posedge clk);
        #1;
        check("midrst_m_tvalid_next", m_tvalid, 0);
        check("midrst_s_tready_next", s_tready, 0);
        m_tready = 1'b0;
        rst_n = 1'b1;
        model_id = 0;
        @(posedge clk);
        #1;
        load_vec(vecs[0]);
        run_frame(0, 1'b0);
        check_fields(vecs[0]);

        // buffer-size boundary: exactly full is sent, one more byte is dropped
        pl_q.delete();
        for (int k = 0; k < MAXP; k++) pl_q.push_back(8'($urandom));
        run_frame(2, 1'b1);
        pl_q.delete();
        for (int k = 0; k < MAXP + 1; k++) pl_q.push_back(8'($urandom));
        run_frame(0, 1'b1);

        for (int f = 0; f < 20; f++) begin
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(MAXP + 1, 300) : $urandom_range(1, MAXP);
            pl_q.delete();
            for (int k = 0; k < len; k++) pl_q.push_back(8'($urandom));
            run_frame(2, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
